pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/sat_counter.sv | 33 +++
 rtl/pipeline_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default parameters for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    localparam int unsigned DEF_MEM_TIMEOUT = 16;
    localparam int unsigned DEF_FLUSH_LEN   = 1;
    localparam int unsigned FCNT_W          = 4;
    localparam int unsigned PERF_W          = 32;
    localparam int unsigned REG_W           = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the optional performance counters.
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned W = PERF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: memory stalls, branch flush, WB->EX forwarding, timeout halt.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int unsigned FLUSH_LEN   = DEF_FLUSH_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_taken,
    input  logic [REG_W-1:0]  ex_rs1,
    input  logic [REG_W-1:0]  ex_rs2,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic              wb_rf_wr,
    input  logic              wb_mem_req,
    input  logic              dmem_ack,
    input  logic              err_clr,
    output logic              pc_en,
    output logic              if_ex_en,
    output logic              ex_wb_en,
    output logic              flush,
    output logic              fwd_op1,
    output logic              fwd_op2,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_cycles
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_LEN - 1);

    state_e              state_q, state_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                mem_err_q, mem_err_d;
    logic                mem_stall;
    logic                timeout_hit;
    logic                en_c, flush_c, fwd1_c, fwd2_c;

    assign mem_stall   = wb_mem_req && !dmem_ack && (state_q != S_HALT);
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_stall && (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A branch seen during a stall stays in the frozen EX stage and is taken once the stall clears.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        mem_err_d = mem_err_q;
        wait_d    = '0;
        if (mem_stall && (wait_q != {WAIT_W{1'b1}})) begin
            wait_d = wait_q + WAIT_W'(1);
        end else if (mem_stall) begin
            wait_d = wait_q;
        end
        unique case (state_q)
            S_RUN: begin
                if (timeout_hit) begin
                    state_d   = S_HALT;
                    mem_err_d = 1'b1;
                end else if (br_taken && !mem_stall && (FLUSH_LEN > 1)) begin
                    state_d = S_FLUSH;
                    fcnt_d  = FLUSH_INIT;
                end
            end
            S_FLUSH: begin
                if (timeout_hit) begin
                    state_d   = S_HALT;
                    mem_err_d = 1'b1;
                end else if (!mem_stall) begin
                    fcnt_d = fcnt_q - FCNT_W'(1);
                    if (fcnt_q == FCNT_W'(1)) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_HALT: begin
                if (err_clr) begin
                    state_d   = S_RUN;
                    mem_err_d = 1'b0;
                    wait_d    = '0;
                    fcnt_d    = '0;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        en_c    = 1'b0;
        flush_c = 1'b1;
        fwd1_c  = 1'b0;
        fwd2_c  = 1'b0;
        unique case (state_q)
            S_RUN: begin
                en_c    = !mem_stall;
                flush_c = br_taken && !mem_stall;
            end
            S_FLUSH: begin
                en_c    = !mem_stall;
                flush_c = 1'b1;
            end
            default: begin
                en_c    = 1'b0;
                flush_c = 1'b1;
            end
        endcase
        if (state_q != S_HALT) begin
            fwd1_c = wb_rf_wr && (wb_rd != '0) && (ex_rs1 == wb_rd);
            fwd2_c = wb_rf_wr && (wb_rd != '0) && (ex_rs2 == wb_rd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q    <= '0;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            fcnt_q    <= fcnt_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Reset forces the safe pipeline view: frozen, flushing, no forwarding.
    assign pc_en    = rst_n && en_c;
    assign if_ex_en = rst_n && en_c;
    assign ex_wb_en = rst_n && en_c;
    assign flush    = !rst_n || flush_c;
    assign fwd_op1  = rst_n && fwd1_c;
    assign fwd_op2  = rst_n && fwd2_c;
    assign mem_err  = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic flush_cnt_inc;
    assign flush_cnt_inc = flush_c && (state_q != S_HALT);

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (mem_stall),
        .count_o (stall_cycles)
    );

    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (flush_cnt_inc),
        .count_o (flush_cycles)
    );
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl (MEM_TIMEOUT=16, FLUSH_LEN=3).
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        br_taken;
    logic [4:0]  ex_rs1, ex_rs2, wb_rd;
    logic        wb_rf_wr, wb_mem_req, dmem_ack, err_clr;
    logic        pc_en, if_ex_en, ex_wb_en, flush, fwd_op1, fwd_op2, mem_err;
    logic [31:0] stall_cycles, flush_cycles;

    logic [6:0]  exp_q[$];
    int          checks;
    int          errors;
    int          m_stall;
    int          m_flush;

    pipeline_ctrl #(.MEM_TIMEOUT(16), .FLUSH_LEN(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .br_taken     (br_taken),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .wb_rd        (wb_rd),
        .wb_rf_wr     (wb_rf_wr),
        .wb_mem_req   (wb_mem_req),
        .dmem_ack     (dmem_ack),
        .err_clr      (err_clr),
        .pc_en        (pc_en),
        .if_ex_en     (if_ex_en),
        .ex_wb_en     (ex_wb_en),
        .flush        (flush),
        .fwd_op1      (fwd_op1),
        .fwd_op2      (fwd_op2),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {pc_en, if_ex_en, ex_wb_en, flush, fwd_op1, fwd_op2, mem_err}
    function automatic logic [6:0] obs();
        return {pc_en, if_ex_en, ex_wb_en, flush, fwd_op1, fwd_op2, mem_err};
    endfunction

    task automatic idle_inputs();
        br_taken   = 1'b0;
        ex_rs1     = 5'd0;
        ex_rs2     = 5'd0;
        wb_rd      = 5'd0;
        wb_rf_wr   = 1'b0;
        wb_mem_req = 1'b0;
        dmem_ack   = 1'b0;
        err_clr    = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        logic [6:0] got;
        idle_inputs();
        rst_n    = 1'b0;
        wb_rf_wr = 1'b1;
        wb_rd    = 5'd5;
        ex_rs1   = 5'd5;
        br_taken = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(7'b000_1_00_0);
        #2;
        got = obs();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", got, e);
        end
        checks++;
        if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_cycles);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        exp_q.push_back(7'b111_0_00_0);
        #2;
        got = obs();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", got, e);
        end
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic test_flush();
        logic [6:0] tbl [4];
        logic [6:0] e;
        logic [6:0] got;
        tbl = '{7'b111_1_00_0, 7'b111_1_00_0, 7'b111_1_00_0, 7'b111_0_00_0};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            br_taken = (c == 0);
            exp_q.push_back(tbl[c]);
            #2;
            got = obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL flush_seq c=%0d got=%b exp=%b", c, got, e);
            end
        end
        m_flush += 3;
        @(negedge clk);
        #2;
        checks++;
        if (flush_cycles !== (PERF ? 32'(m_flush) : 32'd0)) begin
            errors++;
            $display("FAIL flush_count got=%0d exp=%0d", flush_cycles, PERF ? m_flush : 0);
        end
    endtask

    task automatic test_mem_stall();
        logic [6:0] e;
        logic [6:0] got;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            wb_mem_req = (c < 5);
            dmem_ack   = (c == 4);
            exp_q.push_back((c < 4) ? 7'b000_0_00_0 : 7'b111_0_00_0);
            #2;
            got = obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL mem_stall c=%0d got=%b exp=%b", c, got, e);
            end
        end
        idle_inputs();
        m_stall += 4;
        @(negedge clk);
        #2;
        checks++;
        if (stall_cycles !== (PERF ? 32'(m_stall) : 32'd0)) begin
            errors++;
            $display("FAIL stall_count got=%0d exp=%0d", stall_cycles, PERF ? m_stall : 0);
        end
    endtask

    task automatic test_branch_stall();
        logic [6:0] tbl [6];
        logic [6:0] e;
        logic [6:0] got;
        tbl = '{7'b000_0_00_0, 7'b000_0_00_0, 7'b111_1_00_0,
                7'b111_1_00_0, 7'b111_1_00_0, 7'b111_0_00_0};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            br_taken   = (c < 3);
            wb_mem_req = (c < 3);
            dmem_ack   = (c == 2);
            exp_q.push_back(tbl[c]);
            #2;
            got = obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL branch_stall c=%0d got=%b exp=%b", c, got, e);
            end
        end
        idle_inputs();
        m_stall += 2;
        m_flush += 3;
        @(negedge clk);
        #2;
        checks++;
        if (stall_cycles !== (PERF ? 32'(m_stall) : 32'd0) ||
            flush_cycles !== (PERF ? 32'(m_flush) : 32'd0)) begin
            errors++;
            $display("FAIL branch_stall_counts got=%0d/%0d exp=%0d/%0d", stall_cycles,
                     flush_cycles, PERF ? m_stall : 0, PERF ? m_flush : 0);
        end
    endtask

    task automatic test_forward();
        // {rf_wr, rd, rs1, rs2, mem_req, ack}
        logic [17:0] stim [6];
        logic [6:0]  tbl  [6];
        logic [6:0]  e;
        logic [6:0]  got;
        stim = '{{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0},
                 {1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0},
                 {1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0},
                 {1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0},
                 {1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0},
                 {1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1}};
        tbl  = '{7'b111_0_10_0, 7'b111_0_01_0, 7'b111_0_00_0,
                 7'b111_0_00_0, 7'b000_0_11_0, 7'b111_0_11_0};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            {wb_rf_wr, wb_rd, ex_rs1, ex_rs2, wb_mem_req, dmem_ack} = stim[c];
            exp_q.push_back(tbl[c]);
            #2;
            got = obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL forward c=%0d got=%b exp=%b", c, got, e);
            end
        end
        idle_inputs();
        m_stall += 1;
    endtask

    task automatic test_timeout();
        logic [6:0] e;
        logic [6:0] got;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            wb_mem_req = (c < 17);
            dmem_ack   = 1'b0;
            err_clr    = (c == 17);
            wb_rf_wr   = (c >= 16);
            wb_rd      = (c >= 16) ? 5'd3 : 5'd0;
            ex_rs1     = (c >= 16) ? 5'd3 : 5'd0;
            if (c < 16)       exp_q.push_back(7'b000_0_00_0);
            else if (c < 18)  exp_q.push_back(7'b000_1_00_1);
            else              exp_q.push_back(7'b111_0_10_0);
            #2;
            got = obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL timeout c=%0d got=%b exp=%b", c, got, e);
            end
        end
        idle_inputs();
        m_stall += 16;
        @(negedge clk);
        #2;
        checks++;
        if (stall_cycles !== (PERF ? 32'(m_stall) : 32'd0) ||
            flush_cycles !== (PERF ? 32'(m_flush) : 32'd0)) begin
            errors++;
            $display("FAIL timeout_counts got=%0d/%0d exp=%0d/%0d", stall_cycles,
                     flush_cycles, PERF ? m_stall : 0, PERF ? m_flush : 0);
        end
    endtask

    task automatic test_reset_mid_flush();
        logic [6:0] tbl [5];
        logic [6:0] e;
        logic [6:0] got;
        tbl = '{7'b111_1_00_0, 7'b000_1_00_0, 7'b000_1_00_0,
                7'b111_0_00_0, 7'b111_0_00_0};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            br_taken = (c == 0);
            rst_n    = !(c == 1 || c == 2);
            exp_q.push_back(tbl[c]);
            #2;
            got = obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid_flush c=%0d got=%b exp=%b", c, got, e);
            end
            if (c == 1 || c == 4) begin
                checks++;
                if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_mid_flush_counters c=%0d got=%0d/%0d exp=0/0",
                             c, stall_cycles, flush_cycles);
                end
            end
        end
        m_stall = 0;
        m_flush = 0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_stall = 0;
        m_flush = 0;
        test_reset();
        test_flush();
        test_mem_stall();
        test_branch_stall();
        test_forward();
        test_timeout();
        test_reset_mid_flush();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
